// File: rtl/nkmd_dai_rx_mc_pkg.sv
// Shared definitions for the multi-channel DAI receive ring: CPU address map
// bases and the sample-to-bus extension helper.
package nkmd_dai_rx_mc_pkg;

  localparam logic [15:0] ADDR_CNT = 16'hd000;
  localparam logic [15:0] ADDR_POP = 16'hd100;
  localparam logic [15:0] ADDR_OVF = 16'hd200;
  localparam logic [15:0] ADDR_WIN = 16'hf000;

  // raw holds the sample zero-extended; shift the sign bit to bit 31 and back
  function automatic logic [31:0] ext_sample(input logic [31:0] raw, input int width,
                                             input bit sext);
    logic [31:0] sh;
    sh = raw << (32 - width);
    return sext ? 32'($signed(sh) >>> (32 - width)) : raw;
  endfunction

endpackage

// File: rtl/nkmd_dai_ring.sv
// One channel of the DAI receive buffer: circular RAM, read/write pointers,
// unread count and sticky overflow flag.
module nkmd_dai_ring #(
  parameter int WIDTH     = 24,
  parameter int LOG2DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic [LOG2DEPTH:0]   pop_req,
  input  logic                 ovf_clr,
  input  logic [LOG2DEPTH-1:0] rd_k,
  output logic [WIDTH-1:0]     rd_data,
  output logic [LOG2DEPTH:0]   unread,
  output logic                 ovf
);

  localparam int DEPTH = 1 << LOG2DEPTH;
  localparam logic [LOG2DEPTH:0] FULL = (LOG2DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     ram [DEPTH];
  logic [LOG2DEPTH-1:0] rp, wp;
  logic                 push_ok;
  logic [LOG2DEPTH:0]   pop_n;

  // fullness is judged on the pre-pop count, so a full ring drops even while popping
  assign push_ok = push && (unread != FULL);
  assign pop_n   = (pop_req > unread) ? unread : pop_req;
  assign rd_data = ram[rp + rd_k];

  always_ff @(posedge clk) begin
    if (rst) begin
      rp     <= '0;
      wp     <= '0;
      unread <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      rp     <= rp + pop_n[LOG2DEPTH-1:0];
      unread <= unread + {{LOG2DEPTH{1'b0}}, push_ok} - pop_n;
      if (push && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) ram[wp] <= push_data;
  end

endmodule

// File: rtl/nkmd_dai_rx_mc.sv
// Multi-channel DAI receive buffer: per-channel rings exposed to the nkmd CPU
// bus as count/pop, overflow and relative-indexed window registers.
module nkmd_dai_rx_mc
  import nkmd_dai_rx_mc_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int WIDTH     = 24,
  parameter int LOG2DEPTH = 6,
  parameter int SIGNEXT   = 0,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_data_i,
  input  logic [CW-1:0]    rx_ch_i,
  input  logic             rx_ack_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [31:0]      addr_i,
  input  logic             we_i
);

  localparam int CHW = 12 - LOG2DEPTH;

  logic [15:0]          addr;
  logic [CHW-1:0]       win_ch;
  logic                 is_cnt, is_pop, is_ovf, is_win;
  logic [LOG2DEPTH:0]   pop_req  [NCH];
  logic [LOG2DEPTH:0]   unread   [NCH];
  logic [WIDTH-1:0]     win_data [NCH];
  logic [NCH-1:0]       ovf_v;
  logic [31:0]          rd_next;
  logic                 unused_bits;

  assign addr   = addr_i[15:0];
  assign win_ch = addr[11:LOG2DEPTH];
  assign is_cnt = (addr[15:8] == ADDR_CNT[15:8]) && (int'(addr[7:0]) < NCH);
  assign is_pop = (addr[15:8] == ADDR_POP[15:8]) && (int'(addr[7:0]) < NCH);
  assign is_ovf = (addr == ADDR_OVF);
  assign is_win = (addr[15:12] == ADDR_WIN[15:12]) && (int'(win_ch) < NCH);
  assign unused_bits = ^{addr_i[31:16], data_i};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic sel;
    assign sel = (addr[7:0] == 8'(g));
    assign pop_req[g] = !we_i                ? '0 :
                        (is_cnt && sel)      ? (LOG2DEPTH + 1)'(1) :
                        (is_pop && sel)      ? data_i[LOG2DEPTH:0] : '0;

    nkmd_dai_ring #(.WIDTH(WIDTH), .LOG2DEPTH(LOG2DEPTH)) u_ring (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_ack_i && (rx_ch_i == CW'(g))),
      .push_data (rx_data_i),
      .pop_req   (pop_req[g]),
      .ovf_clr   (we_i && is_ovf && data_i[g]),
      .rd_k      (addr[LOG2DEPTH-1:0]),
      .rd_data   (win_data[g]),
      .unread    (unread[g]),
      .ovf       (ovf_v[g])
    );
  end

  // reads see the state before this cycle's push/pop takes effect
  always_comb begin
    rd_next = '0;
    if (is_cnt || is_pop) begin
      for (int i = 0; i < NCH; i++)
        if (addr[7:0] == 8'(i)) rd_next = 32'(unread[i]);
    end else if (is_ovf) begin
      rd_next = 32'(ovf_v);
    end else if (is_win) begin
      for (int i = 0; i < NCH; i++)
        if (win_ch == CHW'(i)) rd_next = ext_sample(32'(win_data[i]), WIDTH, SIGNEXT != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_o <= '0;
    else     data_o <= rd_next;
  end

endmodule

// File: tb/tb_nkmd_dai_rx_mc.sv
// Directed bench for nkmd_dai_rx_mc: reads queue expected values, a monitor
// compares data_o one cycle later on the matching instance.
module tb_nkmd_dai_rx_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rx_data = '0;
  logic [0:0]  rx_ch = '0;
  logic        rx_ack = 1'b0;
  logic [31:0] data_w = '0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] data_o0, data_o1;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic rd_issue = 1'b0, rd_issue_d = 1'b0;
  bit   rd_sel = 1'b0, rd_sel_d = 1'b0;
  int   n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  nkmd_dai_rx_mc #(.NCH(2), .WIDTH(24), .LOG2DEPTH(6), .SIGNEXT(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_ch_i(rx_ch), .rx_ack_i(rx_ack),
    .data_i(data_w), .data_o(data_o0), .addr_i(addr), .we_i(we));

  nkmd_dai_rx_mc #(.NCH(2), .WIDTH(24), .LOG2DEPTH(6), .SIGNEXT(1)) dut1 (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_ch_i(rx_ch), .rx_ack_i(rx_ack),
    .data_i(data_w), .data_o(data_o1), .addr_i(addr), .we_i(we));

  always @(posedge clk) begin
    rd_issue_d <= rd_issue;
    rd_sel_d   <= rd_sel;
  end

  // monitor: one queued expectation per registered read
  initial begin
    forever begin
      @(negedge clk);
      if (rd_issue_d) begin
        logic [31:0] act;
        act = rd_sel_d ? data_o1 : data_o0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_read: got %h, no expectation queued", act);
        end else begin
          cur = exp_q.pop_front();
          if (act !== cur.exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    rx_ack = 1'b0; we = 1'b0; rd_issue = 1'b0; rst = 1'b0;
    addr = '0; data_w = '0;
  endtask

  task automatic push(input bit ch, input logic [23:0] d);
    rx_ack = 1'b1; rx_ch = ch; rx_data = d;
    cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    we = 1'b1; addr = {16'h0, a}; data_w = d;
    cyc();
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e, input bit sel, input string nm);
    exp_t x;
    x.name = nm; x.exp = e; x.sel = sel;
    exp_q.push_back(x);
    addr = {16'h0, a}; rd_issue = 1'b1; rd_sel = sel;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    #1;
    do_reset();
    do_reset();

    rd(16'hd000, 32'h0, 0, "rst_cnt0");
    rd(16'hd001, 32'h0, 0, "rst_cnt1");
    rd(16'hd200, 32'h0, 0, "rst_ovf");
    push(0, 24'hcafebb);
    rd(16'hd000, 32'h1, 0, "cnt_after_push");
    rd(16'hd100, 32'h1, 0, "cnt_alias_d100");
    rd(16'hf000, 32'h00cafebb, 0, "win_zext");
    rd(16'hd001, 32'h0, 0, "cnt_other_ch");
    rd(16'h1234, 32'h0, 0, "unmapped");
    push(1, 24'h800001);
    rd(16'hf040, 32'hff800001, 1, "win_sext");
    rd(16'hf040, 32'h00800001, 0, "win_zext_ch1");

    do_reset();
    for (int i = 0; i < 5; i++) push(0, 24'hbeef00 + 24'(i));
    wr(16'hd100, 32'd3);
    rd(16'hd000, 32'd2, 0, "bulk3_cnt");
    rd(16'hf000, 32'h00beef03, 0, "bulk3_win");
    wr(16'hd100, 32'd9);
    rd(16'hd000, 32'd0, 0, "bulk_clamp_cnt");

    do_reset();
    for (int i = 0; i < 65; i++) push(0, 24'(i));
    rd(16'hd000, 32'd64, 0, "full_cnt");
    rd(16'hd200, 32'd1, 0, "full_ovf");
    rd(16'hf000, 32'd0, 0, "full_win0");
    rd(16'hf03f, 32'd63, 0, "full_win63");
    wr(16'hd200, 32'd1);
    rd(16'hd200, 32'd0, 0, "ovf_w1c");
    rx_ack = 1'b1; rx_ch = 1'b0; rx_data = 24'd100;
    we = 1'b1; addr = 32'h0000d000;
    cyc();
    rd(16'hd000, 32'd63, 0, "pushpop_full_cnt");
    rd(16'hd200, 32'd1, 0, "pushpop_full_ovf");
    rd(16'hf000, 32'd1, 0, "pushpop_win0");
    rd(16'hf03e, 32'd63, 0, "pushpop_win62");
    rd(16'hf03f, 32'd0, 0, "pushpop_dropped");

    do_reset();
    for (int i = 0; i < 60; i++) push(0, 24'(i));
    wr(16'hd100, 32'd58);
    for (int i = 60; i < 68; i++) push(0, 24'(i));
    rd(16'hd000, 32'd10, 0, "wrap_cnt");
    for (int i = 0; i < 10; i++) begin
      rd(16'hf000, 32'(58 + i), 0, $sformatf("wrap_seq%0d", i));
      wr(16'hd000, 32'h0);
    end
    rd(16'hd000, 32'd0, 0, "wrap_drained");

    for (int i = 0; i < 4; i++) push(1'(i), 24'h111 * 24'(i + 1));
    rx_ack = 1'b1; rx_ch = 1'b0; rx_data = 24'h777;
    we = 1'b1; data_w = 32'h0;
    rst = 1'b1;
    addr = 32'h0000d000; rd_issue = 1'b1; rd_sel = 1'b0;
    exp_q.push_back('{name: "rst_data_o", exp: 32'h0, sel: 1'b0});
    cyc();
    rd(16'hd000, 32'd0, 0, "midrst_cnt0");
    rd(16'hd001, 32'd0, 0, "midrst_cnt1");
    rd(16'hd200, 32'd0, 0, "midrst_ovf");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
